// File: rtl/hazard_unit_mc_pkg.sv
// Shared opcode/funct constants, the load-stall FSM state type and small
// instruction-class decode helpers for the multi-cycle hazard unit.
// Exports: package hazard_pkg (no ports).
package hazard_pkg;

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;

    localparam logic [5:0] FnJr      = 6'h08;
    localparam logic [5:0] FnJalr    = 6'h09;
    localparam logic [5:0] FnMfhi    = 6'h10;
    localparam logic [5:0] FnMflo    = 6'h12;
    localparam logic [5:0] FnMult    = 6'h18;
    localparam logic [5:0] FnMultu   = 6'h19;
    localparam logic [5:0] FnDiv     = 6'h1A;
    localparam logic [5:0] FnDivu    = 6'h1B;

    typedef enum logic [0:0] {
        StIdle,
        StLstall
    } load_st_e;

    // Unconditional control transfer decoded in ID.
    function automatic logic is_jump(logic [5:0] op, logic [5:0] fn);
        return (op == OpJ) || (op == OpJal) ||
               ((op == OpSpecial) && ((fn == FnJr) || (fn == FnJalr)));
    endfunction

    // Instructions that touch HI/LO and must wait for the MDU to finish.
    function automatic logic uses_hilo(logic [5:0] op, logic [5:0] fn);
        return (op == OpSpecial) &&
               ((fn == FnMfhi) || (fn == FnMflo) || (fn == FnMult) ||
                (fn == FnMultu) || (fn == FnDiv) || (fn == FnDivu));
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Bundle of ID/EX hazard inputs and pipeline control outputs.
// master: pipeline side (drives instruction fields, receives controls).
// slave:  hazard unit (receives fields, drives pc/if-id enables, flushes,
//         mdu_busy and, with HAZARD_PERF_EN defined, the perf counters).
interface hazard_unit_mc_if #(
    parameter int unsigned REG_AW = 5
);

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [5:0]        id_opcode;
    logic [5:0]        id_funct;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_mem_rd;
    logic              ex_branch_taken;
    logic              ex_mdu_start;

    logic              pc_wr_en;
    logic              if_id_wr_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              mdu_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_flushes;

    modport master (
        output id_rs, id_rt, id_opcode, id_funct, ex_rt, ex_mem_rd,
               ex_branch_taken, ex_mdu_start,
        input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, mdu_busy,
               perf_stall_cycles, perf_flushes
    );

    modport slave (
        input  id_rs, id_rt, id_opcode, id_funct, ex_rt, ex_mem_rd,
               ex_branch_taken, ex_mdu_start,
        output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, mdu_busy,
               perf_stall_cycles, perf_flushes
    );
`else
    modport master (
        output id_rs, id_rt, id_opcode, id_funct, ex_rt, ex_mem_rd,
               ex_branch_taken, ex_mdu_start,
        input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, mdu_busy
    );

    modport slave (
        input  id_rs, id_rt, id_opcode, id_funct, ex_rt, ex_mem_rd,
               ex_branch_taken, ex_mdu_start,
        output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, mdu_busy
    );
`endif

endinterface

// File: rtl/hazard_unit_mc_lat_counter.sv
// hazard_lat_counter: loadable down-counter that saturates at zero.
// Ports: clk_i, reset_i (sync, active-high), clear_i (sync clear),
//        load_i/load_val_i (load, beats decrement), dec_i (count down),
//        cnt_o (current value), nonzero_o (cnt_o != 0).
module hazard_lat_counter #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             nonzero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: multi-cycle hazard control beside the ID stage.
// Handles load-use stalls lasting LOAD_LAT cycles, HI/LO stalls while the
// multiply/divide unit is busy for MDU_LAT cycles, jump and taken-branch
// flushes. Priority: reset > branch > load stall > MDU stall > jump.
// Ports: clk, reset (synchronous, active-high), hz (hazard_unit_mc_if.slave).
// Optional: define HAZARD_PERF_EN to add saturating perf_stall_cycles and
// perf_flushes counters on the interface.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 32
) (
    input logic              clk,
    input logic              reset,
    hazard_unit_mc_if.slave  hz
);

    localparam int unsigned LoadCw = $clog2(LOAD_LAT + 1);
    localparam int unsigned MduCw  = $clog2(MDU_LAT + 1);
    localparam logic [LoadCw-1:0] LoadInit = LoadCw'(LOAD_LAT - 1);
    localparam logic [MduCw-1:0]  MduInit  = MduCw'(MDU_LAT - 1);

    logic [REG_AW-1:0] rs, rt, ert;
    assign rs  = hz.id_rs;
    assign rt  = hz.id_rt;
    assign ert = hz.ex_rt;

    logic branch, load_hit, load_start, load_stall, mdu_stall, jump;
    logic [LoadCw-1:0] load_cnt;
    logic              load_nz;
    logic [MduCw-1:0]  unused_mdu_cnt;
    logic              mdu_nz, mdu_busy;
    load_st_e          state_q;

    assign branch   = hz.ex_branch_taken;
    // $zero is hard-wired, so a load into it can never create a dependency.
    assign load_hit = hz.ex_mem_rd && (ert != '0) && ((ert == rs) || (ert == rt));

    // A single-cycle latency is covered entirely by the IDLE-state stall.
    assign load_start = !branch && (state_q == StIdle) && load_hit && (LOAD_LAT > 1);
    assign load_stall = ((state_q == StLstall) && load_nz) ||
                        ((state_q == StIdle) && load_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        state_q <= StLstall;
                    end
                end
                StLstall: begin
                    if (branch || (load_cnt == LoadCw'(1))) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    hazard_lat_counter #(
        .Width (LoadCw)
    ) u_load_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (branch),
        .load_i     (load_start),
        .load_val_i (LoadInit),
        .dec_i      (state_q == StLstall),
        .cnt_o      (load_cnt),
        .nonzero_o  (load_nz)
    );

    hazard_lat_counter #(
        .Width (MduCw)
    ) u_mdu_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (1'b0),
        .load_i     (hz.ex_mdu_start),
        .load_val_i (MduInit),
        .dec_i      (1'b1),
        .cnt_o      (unused_mdu_cnt),
        .nonzero_o  (mdu_nz)
    );

    // The issuing cycle already counts as busy.
    assign mdu_busy  = !reset && (mdu_nz || hz.ex_mdu_start);
    assign mdu_stall = mdu_busy && uses_hilo(hz.id_opcode, hz.id_funct);
    assign jump      = is_jump(hz.id_opcode, hz.id_funct);

    logic pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush;

    always_comb begin
        pc_wr_en    = 1'b1;
        if_id_wr_en = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset) begin
            // Pipeline free-runs during reset.
        end else if (branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_stall || mdu_stall) begin
            pc_wr_en    = 1'b0;
            if_id_wr_en = 1'b0;
            id_ex_flush = 1'b1;
        end else if (jump) begin
            if_id_flush = 1'b1;
        end
    end

    assign hz.pc_wr_en    = pc_wr_en;
    assign hz.if_id_wr_en = if_id_wr_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.mdu_busy    = mdu_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (!pc_wr_en && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if ((if_id_flush || id_ex_flush) && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign hz.perf_stall_cycles = perf_stall_q;
    assign hz.perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc. Three instances with different
// latencies share one stimulus stream: 0 = (LOAD 3, MDU 4),
// 1 = (LOAD 1, MDU 2), 2 = (LOAD 2, MDU 4).
module tb_hazard_unit_mc;

    localparam int unsigned NDut = 3;
    localparam int unsigned LLAT [NDut] = '{3, 1, 2};
    localparam int unsigned MLAT [NDut] = '{4, 2, 4};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic [5:0] id_op = '0, id_fn = 6'h20;
    logic       mem_rd = 1'b0, br = 1'b0, mdu = 1'b0;

    always #5 clk = ~clk;

    logic        act_pc [NDut];
    logic        act_ifwr [NDut];
    logic        act_iff [NDut];
    logic        act_idf [NDut];
    logic        act_busy [NDut];
    logic [31:0] act_ps [NDut];
    logic [31:0] act_pf [NDut];

    hazard_unit_mc_if #(.REG_AW(5)) hif [NDut] ();

    for (genvar k = 0; k < NDut; k++) begin : g_dut
        assign hif[k].id_rs           = id_rs;
        assign hif[k].id_rt           = id_rt;
        assign hif[k].id_opcode       = id_op;
        assign hif[k].id_funct        = id_fn;
        assign hif[k].ex_rt           = ex_rt;
        assign hif[k].ex_mem_rd       = mem_rd;
        assign hif[k].ex_branch_taken = br;
        assign hif[k].ex_mdu_start    = mdu;

        assign act_pc[k]   = hif[k].pc_wr_en;
        assign act_ifwr[k] = hif[k].if_id_wr_en;
        assign act_iff[k]  = hif[k].if_id_flush;
        assign act_idf[k]  = hif[k].id_ex_flush;
        assign act_busy[k] = hif[k].mdu_busy;
`ifdef HAZARD_PERF_EN
        assign act_ps[k]   = hif[k].perf_stall_cycles;
        assign act_pf[k]   = hif[k].perf_flushes;
`else
        assign act_ps[k]   = '0;
        assign act_pf[k]   = '0;
`endif

        hazard_unit_mc #(
            .REG_AW   (5),
            .LOAD_LAT (LLAT[k]),
            .MDU_LAT  (MLAT[k])
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .hz    (hif[k])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a load stall occupies the cycles [hit, hit+LOAD_LAT); the MDU is
    // busy on cycles within MDU_LAT of its latest start.
    int     cyc = 0;
    int     load_end [NDut] = '{0, 0, 0};
    int     mdu_last [NDut] = '{-1000, -1000, -1000};
    longint p_st [NDut] = '{0, 0, 0};
    longint p_fl [NDut] = '{0, 0, 0};

    always @(negedge clk) begin
        logic hit, hl, jmp, busy, in_st, e_pc, e_iff, e_idf;
        hit = mem_rd && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        hl  = (id_op == 0) && ((id_fn == 6'h10) || (id_fn == 6'h12) || (id_fn == 6'h18) ||
                               (id_fn == 6'h19) || (id_fn == 6'h1A) || (id_fn == 6'h1B));
        jmp = (id_op == 2) || (id_op == 3) || ((id_op == 0) && ((id_fn == 8) || (id_fn == 9)));
        for (int k = 0; k < NDut; k++) begin
            busy  = !reset && (mdu || ((cyc - mdu_last[k]) < int'(MLAT[k])));
            in_st = cyc < load_end[k];
            e_pc  = 1'b1;
            e_iff = 1'b0;
            e_idf = 1'b0;
            if (reset) begin
                load_end[k] = 0;
            end else if (br) begin
                e_iff = 1'b1;
                e_idf = 1'b1;
                load_end[k] = 0;
            end else if (in_st || hit) begin
                e_pc  = 1'b0;
                e_idf = 1'b1;
                if (!in_st) load_end[k] = cyc + int'(LLAT[k]);
            end else if (hl && busy) begin
                e_pc  = 1'b0;
                e_idf = 1'b1;
            end else if (jmp) begin
                e_iff = 1'b1;
            end
            chk($sformatf("pc_wr_en[%0d]", k), 32'(act_pc[k]), 32'(e_pc));
            chk($sformatf("if_id_wr_en[%0d]", k), 32'(act_ifwr[k]), 32'(e_pc));
            chk($sformatf("if_id_flush[%0d]", k), 32'(act_iff[k]), 32'(e_iff));
            chk($sformatf("id_ex_flush[%0d]", k), 32'(act_idf[k]), 32'(e_idf));
            chk($sformatf("mdu_busy[%0d]", k), 32'(act_busy[k]), 32'(busy));
`ifdef HAZARD_PERF_EN
            chk($sformatf("perf_stall[%0d]", k), act_ps[k], 32'(p_st[k]));
            chk($sformatf("perf_flush[%0d]", k), act_pf[k], 32'(p_fl[k]));
            if (reset) begin
                p_st[k] = 0;
                p_fl[k] = 0;
            end else begin
                if (!e_pc && p_st[k] < 64'hFFFF_FFFF) p_st[k]++;
                if ((e_iff || e_idf) && p_fl[k] < 64'hFFFF_FFFF) p_fl[k]++;
            end
`endif
            if (reset) mdu_last[k] = -1000;
            else if (mdu) mdu_last[k] = cyc;
        end
        cyc++;
    end

    // Drive one cycle's inputs shortly after the edge, leave time to settle.
    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] op,
                          input logic [5:0] fn, input logic [4:0] ert, input logic mr,
                          input logic b, input logic m);
        id_rs  = rs;
        id_rt  = rt;
        id_op  = op;
        id_fn  = fn;
        ex_rt  = ert;
        mem_rd = mr;
        br     = b;
        mdu    = m;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, with an MDU start that reset must mask.
        reset = 1'b1;
        set_in(0, 0, 0, 6'h20, 0, 0, 0, 1);
        chk("rst_pc", 32'(act_pc[0]), 1);
        chk("rst_busy", 32'(act_busy[0]), 0);
        tick();
        set_in(0, 0, 0, 6'h20, 0, 0, 0, 0);
        chk("rst_idf", 32'(act_idf[0]), 0);
        tick();
        reset = 1'b0;

        // Load-use on rs: A stalls 3, B 1, C 2.
        set_in(3, 5, 0, 6'h20, 3, 1, 0, 0);
        chk("lu0_pc_a", 32'(act_pc[0]), 0);
        chk("lu0_idf_a", 32'(act_idf[0]), 1);
        chk("lu0_pc_b", 32'(act_pc[1]), 0);
        tick();
        set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
        chk("lu1_pc_b", 32'(act_pc[1]), 1);
        chk("lu1_pc_a", 32'(act_pc[0]), 0);
        tick();
        set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
        chk("lu2_pc_a", 32'(act_pc[0]), 0);
        chk("lu2_pc_c", 32'(act_pc[2]), 1);
        tick();
        set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
        chk("lu3_pc_a", 32'(act_pc[0]), 1);
        tick();

        // Load into $zero never stalls; rt dependency does.
        set_in(0, 0, 0, 6'h20, 0, 1, 0, 0);
        chk("r0_pc_a", 32'(act_pc[0]), 1);
        tick();
        set_in(1, 7, 0, 6'h20, 7, 1, 0, 0);
        chk("rt_idf_b", 32'(act_idf[1]), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 7, 0, 6'h20, 0, 0, 0, 0);
            tick();
        end

        // MDU issue then mflo: A stalled 4 cycles, released on the 5th.
        for (int m = 0; m < 6; m++) begin
            set_in(0, 0, 0, 6'h12, 0, 0, 0, (m == 0));
            if (m == 0) chk("mdu0_busy_a", 32'(act_busy[0]), 1);
            if (m == 2) chk("mdu2_pc_b", 32'(act_pc[1]), 1);
            if (m == 3) chk("mdu3_pc_a", 32'(act_pc[0]), 0);
            if (m == 4) chk("mdu4_pc_a", 32'(act_pc[0]), 1);
            if (m == 4) chk("mdu4_busy_a", 32'(act_busy[0]), 0);
            tick();
        end
        // Restart while busy reloads; mfhi waits on the later issue.
        for (int m = 0; m < 7; m++) begin
            set_in(0, 0, 0, 6'h10, 0, 0, 0, (m == 0) || (m == 2));
            if (m == 5) chk("rst5_pc_a", 32'(act_pc[0]), 0);
            if (m == 6) chk("rst6_pc_a", 32'(act_pc[0]), 1);
            tick();
        end
        // Non-SPECIAL opcode with an mfhi funct is not a HI/LO reader.
        set_in(0, 0, 6'h23, 6'h10, 0, 0, 0, 1);
        chk("notmf_pc_a", 32'(act_pc[0]), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 6'h20, 0, 0, 0, 0);
            tick();
        end

        // Reset in the second stall cycle aborts the stall.
        set_in(3, 5, 0, 6'h20, 3, 1, 0, 0);
        tick();
        reset = 1'b1;
        set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
        chk("rstmid_pc_a", 32'(act_pc[0]), 1);
        tick();
        reset = 1'b0;
        set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
        chk("rstpost_pc_a", 32'(act_pc[0]), 1);
        tick();

        // Branch together with a load hit: branch wins, no stall follows.
        set_in(3, 5, 0, 6'h20, 3, 1, 1, 0);
        chk("brhit_pc_a", 32'(act_pc[0]), 1);
        chk("brhit_iff_a", 32'(act_iff[0]), 1);
        chk("brhit_idf_a", 32'(act_idf[0]), 1);
        tick();
        set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
        chk("brpost_pc_a", 32'(act_pc[0]), 1);
        tick();
        // Branch in the middle of a stall aborts it.
        set_in(3, 5, 0, 6'h20, 3, 1, 0, 0);
        tick();
        set_in(3, 5, 0, 6'h20, 0, 0, 1, 0);
        tick();
        set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
        chk("brmid_pc_a", 32'(act_pc[0]), 1);
        tick();

        // jr with no stall flushes IF/ID for one cycle.
        set_in(31, 0, 0, 6'h08, 0, 0, 0, 0);
        chk("jr_iff_a", 32'(act_iff[0]), 1);
        tick();
        set_in(0, 0, 0, 6'h20, 0, 0, 0, 0);
        chk("jrpost_iff_a", 32'(act_iff[0]), 0);
        tick();
        // jr held during a load stall: flush only once the stall ends.
        for (int j = 0; j < 4; j++) begin
            set_in(3, 0, 0, 6'h08, (j == 0) ? 5'd3 : 5'd0, (j == 0), 0, 0);
            if (j < 3) chk("jrst_iff_a", 32'(act_iff[0]), 0);
            if (j == 1) chk("jrst1_iff_b", 32'(act_iff[1]), 1);
            if (j == 3) chk("jrst3_iff_a", 32'(act_iff[0]), 1);
            tick();
        end
        set_in(0, 0, 6'h02, 6'h00, 0, 0, 0, 0);
        chk("j_iff_a", 32'(act_iff[0]), 1);
        tick();
        set_in(0, 0, 6'h01, 6'h09, 0, 0, 0, 0);
        chk("notjalr_iff_a", 32'(act_iff[0]), 0);
        tick();

`ifdef HAZARD_PERF_EN
        // Two load stalls plus one branch on instance C (LOAD_LAT=2).
        reset = 1'b1;
        set_in(0, 0, 0, 6'h20, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            set_in(3, 5, 0, 6'h20, 3, 1, 0, 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                set_in(3, 5, 0, 6'h20, 0, 0, 0, 0);
                tick();
            end
        end
        set_in(3, 5, 0, 6'h20, 0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 6'h20, 0, 0, 0, 0);
        chk("perf_stall_c", act_ps[2], 4);
        chk("perf_flush_c", act_pf[2], 5);
        tick();
`endif

        set_in(0, 0, 0, 6'h20, 0, 0, 0, 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
